reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, register data width; shall match the register file width.
REQ-002 Parameter: ADDR_W, 3, register address width (8 registers).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 a_valid / b_valid  in  1  requester A/B has a request pending.
REQ-006 a_ready / b_ready  out  1  request accepted at this rising edge.
REQ-007 a_we / b_we  in  1  request includes a write.
REQ-008 a_ra1, a_ra2, b_ra1, b_ra2  in  ADDR_W  read addresses.
REQ-009 a_wa / b_wa  in  ADDR_W  write address; a_wd / b_wd  in  DATA_W  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse, response data valid.
REQ-011 rsp_id  out  1  0 = response for A, 1 = response for B.
REQ-012 rsp_d1, rsp_d2  out  DATA_W  read data for ra1/ra2.
REQ-013 rf_r_en, rf_w_en  out  1  register file read/write enables.
REQ-014 rf_addr_r1, rf_addr_r2, rf_addr_w1, rf_addr_w2  out  ADDR_W  register file addresses.
REQ-015 rf_wd1, rf_wd2  out  DATA_W  register file write data; rf_rd1, rf_rd2  in  DATA_W  register file read data.

Function
REQ-016 FSM states IDLE and ISSUE; one request in flight at most.
REQ-017 IDLE: grant computed combinationally from valids; granted requester's ready=1; on that edge, request fields are latched, grant recorded, state -> ISSUE.
REQ-018 IDLE with no valid: both ready=0, state stays IDLE.
REQ-019 ISSUE lasts exactly one cycle: rf_r_en=1, rf_w_en=latched we, rf_addr_r1/r2=latched ra1/ra2, rf_addr_w1=rf_addr_w2=latched wa, rf_wd1=rf_wd2=latched wd; both ready=0.
REQ-020 IDLE: all rf_* outputs 0.
REQ-021 Rising edge ending ISSUE: rf_rd1/rf_rd2 captured into rsp_d1/rsp_d2, rsp_id=latched grant, rsp_valid=1 for one cycle, state -> IDLE.
REQ-022 Latency: accept at edge N, rsp_valid high in cycle after edge N+1; peak throughput one request per 2 cycles.
REQ-023 Register file writes on falling clk inside ISSUE; a read of the address written by the same request returns the new data.
REQ-024 rsp_d1/rsp_d2 hold last value when rsp_valid=0.
REQ-025 Requester dropping valid before ready: nothing latched, no side effect.
REQ-026 Arbitration with both valid per Configuration; single valid always granted.

Reset
REQ-027 rst=1 forces immediately: state IDLE, rsp_valid 0, rsp_id 0, rsp_d1/rsp_d2 0, latched request 0, priority pointer to A.
REQ-028 rst during ISSUE: rf_w_en drops asynchronously, in-flight request discarded, no response issued.
REQ-029 First edge after rst release behaves as IDLE.

Configuration
REQ-030 Macro REGARB_RR_EN defined: round-robin; both valid -> grant requester not granted last; pointer updates on every grant.
REQ-031 REGARB_RR_EN undefined: fixed priority, A always wins when both valid; pointer logic absent.

Verification
REQ-032 A only: a_we=1, a_wa=3, a_wd=0x5A, a_ra1=3, a_ra2=0 -> a_ready at N, rf_w_en=1 one cycle, rsp_valid after N+1, rsp_id=0, rsp_d1=0x5A, rsp_d2=0x00.
REQ-033 A and B valid continuously, RR build -> grants A,B,A,B; rsp_id 0,1,0,1 every 2 cycles.
REQ-034 A and B valid continuously, fixed build -> only A granted; b_ready never 1 while a_valid=1.
REQ-035 Assert rst mid-ISSUE with a_we=1, a_wa=5, a_wd=0xFF -> rf_w_en falls immediately, no rsp_valid, IDLE after release.
REQ-036 B writes r7=0x11 then reads r7 -> second response rsp_id=1, rsp_d1=0x11; rf_* all 0 while IDLE.

Source files
------------

// File: rtl/reg_arbiter.sv
// reg_arbiter: two-requester front end for a 2-read/2-write register file, one request in flight.
// Build option REGARB_RR_EN selects round-robin arbitration; default build uses fixed A priority.
module reg_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_ra1_i,
    input  logic [ADDR_W-1:0] a_ra2_i,
    input  logic [ADDR_W-1:0] a_wa_i,
    input  logic [DATA_W-1:0] a_wd_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_ra1_i,
    input  logic [ADDR_W-1:0] b_ra2_i,
    input  logic [ADDR_W-1:0] b_wa_i,
    input  logic [DATA_W-1:0] b_wd_i,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_d1_o,
    output logic [DATA_W-1:0] rsp_d2_o,
    output logic              rf_r_en_o,
    output logic              rf_w_en_o,
    output logic [ADDR_W-1:0] rf_addr_r1_o,
    output logic [ADDR_W-1:0] rf_addr_r2_o,
    output logic [ADDR_W-1:0] rf_addr_w1_o,
    output logic [ADDR_W-1:0] rf_addr_w2_o,
    output logic [DATA_W-1:0] rf_wd1_o,
    output logic [DATA_W-1:0] rf_wd2_o,
    input  logic [DATA_W-1:0] rf_rd1_i,
    input  logic [DATA_W-1:0] rf_rd2_i
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t              state_q;
    logic                grant_q;
    logic                rf_r_en_q, rf_w_en_q;
    logic [ADDR_W-1:0]   ra1_q, ra2_q, wa_q;
    logic [DATA_W-1:0]   wd_q;
    logic                rsp_valid_q, rsp_id_q;
    logic [DATA_W-1:0]   rsp_d1_q, rsp_d2_q;
`ifdef REGARB_RR_EN
    logic                prio_b_q;
`endif

    logic                accept_d, grant_b_d, we_d;
    logic [ADDR_W-1:0]   ra1_d, ra2_d, wa_d;
    logic [DATA_W-1:0]   wd_d;

    always_comb begin
        accept_d  = (state_q == IDLE) && (a_valid_i || b_valid_i);
`ifdef REGARB_RR_EN
        grant_b_d = b_valid_i && (!a_valid_i || prio_b_q);
`else
        grant_b_d = b_valid_i && !a_valid_i;
`endif
        we_d  = grant_b_d ? b_we_i  : a_we_i;
        ra1_d = grant_b_d ? b_ra1_i : a_ra1_i;
        ra2_d = grant_b_d ? b_ra2_i : a_ra2_i;
        wa_d  = grant_b_d ? b_wa_i  : a_wa_i;
        wd_d  = grant_b_d ? b_wd_i  : a_wd_i;
    end

    assign a_ready_o = accept_d && !grant_b_d;
    assign b_ready_o = accept_d && grant_b_d;

    // The rf_* registers double as the latched request: they are loaded on accept and cleared
    // when ISSUE ends, so reset dropping them also discards the in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            rf_r_en_q   <= 1'b0;
            rf_w_en_q   <= 1'b0;
            ra1_q       <= '0;
            ra2_q       <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_d1_q    <= '0;
            rsp_d2_q    <= '0;
`ifdef REGARB_RR_EN
            prio_b_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (accept_d) begin
                        state_q   <= ISSUE;
                        grant_q   <= grant_b_d;
                        rf_r_en_q <= 1'b1;
                        rf_w_en_q <= we_d;
                        ra1_q     <= ra1_d;
                        ra2_q     <= ra2_d;
                        wa_q      <= wa_d;
                        wd_q      <= wd_d;
`ifdef REGARB_RR_EN
                        prio_b_q  <= !grant_b_d;
`endif
                    end
                end
                ISSUE: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= grant_q;
                    rsp_d1_q    <= rf_rd1_i;
                    rsp_d2_q    <= rf_rd2_i;
                    grant_q     <= 1'b0;
                    rf_r_en_q   <= 1'b0;
                    rf_w_en_q   <= 1'b0;
                    ra1_q       <= '0;
                    ra2_q       <= '0;
                    wa_q        <= '0;
                    wd_q        <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_d1_o     = rsp_d1_q;
    assign rsp_d2_o     = rsp_d2_q;
    assign rf_r_en_o    = rf_r_en_q;
    assign rf_w_en_o    = rf_w_en_q;
    assign rf_addr_r1_o = ra1_q;
    assign rf_addr_r2_o = ra2_q;
    assign rf_addr_w1_o = wa_q;
    assign rf_addr_w2_o = wa_q;
    assign rf_wd1_o     = wd_q;
    assign rf_wd2_o     = wd_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: directed and random traffic against reg_arbiter with a behavioural
// register-file and request-level reference model; arbitration expectation follows REGARB_RR_EN.
module tb_reg_arbiter;

    logic       clk, rst;
    logic       a_valid, a_ready, a_we, b_valid, b_ready, b_we;
    logic [2:0] a_ra1, a_ra2, a_wa, b_ra1, b_ra2, b_wa;
    logic [7:0] a_wd, b_wd;
    logic       rsp_valid, rsp_id;
    logic [7:0] rsp_d1, rsp_d2;
    logic       rf_r_en, rf_w_en;
    logic [2:0] rf_addr_r1, rf_addr_r2, rf_addr_w1, rf_addr_w2;
    logic [7:0] rf_wd1, rf_wd2, rf_rd1, rf_rd2;

    reg_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_we_i(a_we),
        .a_ra1_i(a_ra1), .a_ra2_i(a_ra2), .a_wa_i(a_wa), .a_wd_i(a_wd),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we),
        .b_ra1_i(b_ra1), .b_ra2_i(b_ra2), .b_wa_i(b_wa), .b_wd_i(b_wd),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_d1_o(rsp_d1), .rsp_d2_o(rsp_d2),
        .rf_r_en_o(rf_r_en), .rf_w_en_o(rf_w_en),
        .rf_addr_r1_o(rf_addr_r1), .rf_addr_r2_o(rf_addr_r2),
        .rf_addr_w1_o(rf_addr_w1), .rf_addr_w2_o(rf_addr_w2),
        .rf_wd1_o(rf_wd1), .rf_wd2_o(rf_wd2),
        .rf_rd1_i(rf_rd1), .rf_rd2_i(rf_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file attached to the DUT: writes land on the falling edge, reads are combinational.
    logic [7:0] rfMem [8];
    always @(negedge clk) begin
        if (rf_w_en) begin
            rfMem[rf_addr_w1] <= rf_wd1;
            rfMem[rf_addr_w2] <= rf_wd2;
        end
    end
    assign rf_rd1 = rfMem[rf_addr_r1];
    assign rf_rd2 = rfMem[rf_addr_r2];

    typedef struct {
        bit       we;
        bit [2:0] ra1, ra2, wa;
        bit [7:0] wd;
        bit       id;
    } req_t;

    int       nVectors = 0;
    int       nMiscompares = 0;
    bit [7:0] mRegs [8];
    bit       mIssuing;
    bit       mLastWasB;
    req_t     mCur;
    bit       expRspValid, expRspId;
    bit [7:0] expD1, expD2;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic setA(input bit v, input bit we, input bit [2:0] ra1, input bit [2:0] ra2,
                        input bit [2:0] wa, input bit [7:0] wd);
        a_valid = v; a_we = we; a_ra1 = ra1; a_ra2 = ra2; a_wa = wa; a_wd = wd;
    endtask

    task automatic setB(input bit v, input bit we, input bit [2:0] ra1, input bit [2:0] ra2,
                        input bit [2:0] wa, input bit [7:0] wd);
        b_valid = v; b_we = we; b_ra1 = ra1; b_ra2 = ra2; b_wa = wa; b_wd = wd;
    endtask

    task automatic modelReset();
        mIssuing    = 1'b0;
        mLastWasB   = 1'b1;
        expRspValid = 1'b0;
        expRspId    = 1'b0;
        expD1       = 8'h00;
        expD2       = 8'h00;
    endtask

    // Called at posedge+1 with inputs already driven; checks the cycle and the following edge.
    task automatic applyStimulus();
        bit   winnerB, expA, expB;
        req_t nreq;
        #3;
        expA = 1'b0;
        expB = 1'b0;
        winnerB = 1'b0;
        if (!mIssuing) begin
            if (a_valid && b_valid) begin
`ifdef REGARB_RR_EN
                winnerB = !mLastWasB;
`else
                winnerB = 1'b0;
`endif
            end else begin
                winnerB = b_valid;
            end
            expA = a_valid && !winnerB;
            expB = b_valid && winnerB;
        end
        checkOutput("a_ready", a_ready, expA);
        checkOutput("b_ready", b_ready, expB);
        checkOutput("rf_r_en", rf_r_en, mIssuing);
        checkOutput("rf_w_en", rf_w_en, mIssuing ? mCur.we : 1'b0);
        checkOutput("rf_addr_r1", rf_addr_r1, mIssuing ? mCur.ra1 : 3'd0);
        checkOutput("rf_addr_r2", rf_addr_r2, mIssuing ? mCur.ra2 : 3'd0);
        checkOutput("rf_addr_w1", rf_addr_w1, mIssuing ? mCur.wa : 3'd0);
        checkOutput("rf_addr_w2", rf_addr_w2, mIssuing ? mCur.wa : 3'd0);
        checkOutput("rf_wd1", rf_wd1, mIssuing ? mCur.wd : 8'd0);
        checkOutput("rf_wd2", rf_wd2, mIssuing ? mCur.wd : 8'd0);

        if (mIssuing) begin
            if (mCur.we) mRegs[mCur.wa] = mCur.wd;
            expRspValid = 1'b1;
            expRspId    = mCur.id;
            expD1       = mRegs[mCur.ra1];
            expD2       = mRegs[mCur.ra2];
            mIssuing    = 1'b0;
        end else begin
            expRspValid = 1'b0;
            if (expA || expB) begin
                if (expB) begin
                    nreq.we = b_we; nreq.ra1 = b_ra1; nreq.ra2 = b_ra2;
                    nreq.wa = b_wa; nreq.wd = b_wd; nreq.id = 1'b1;
                end else begin
                    nreq.we = a_we; nreq.ra1 = a_ra1; nreq.ra2 = a_ra2;
                    nreq.wa = a_wa; nreq.wd = a_wd; nreq.id = 1'b0;
                end
                mCur      = nreq;
                mIssuing  = 1'b1;
                mLastWasB = expB;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("rsp_valid", rsp_valid, expRspValid);
        checkOutput("rsp_id", rsp_id, expRspId);
        checkOutput("rsp_d1", rsp_d1, expD1);
        checkOutput("rsp_d2", rsp_d2, expD2);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rfMem[i] = 8'h00;
            mRegs[i] = 8'h00;
        end
        modelReset();
        rst = 1'b1;
        setA(0, 0, 0, 0, 0, 8'h00);
        setB(0, 0, 0, 0, 0, 8'h00);
        #3;
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_rsp_id", rsp_id, 1'b0);
        checkOutput("reset_rsp_d1", rsp_d1, 8'h00);
        checkOutput("reset_rf_r_en", rf_r_en, 1'b0);
        checkOutput("reset_a_ready", a_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] A writes r3=5A and reads r3/r0");
        setA(1, 1, 3'd3, 3'd0, 3'd3, 8'h5A);
        applyStimulus();
        setA(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();
        checkOutput("a_write_read_d1", rsp_d1, 8'h5A);
        checkOutput("a_write_read_d2", rsp_d2, 8'h00);
        applyStimulus();
        applyStimulus();

        $display("[TB] B writes r7=11 then reads r7");
        setB(1, 1, 3'd0, 3'd3, 3'd7, 8'h11);
        applyStimulus();
        setB(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();
        setB(1, 0, 3'd7, 3'd3, 3'd2, 8'hEE);
        applyStimulus();
        setB(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();
        checkOutput("b_read_r7_id", rsp_id, 1'b1);
        checkOutput("b_read_r7_d1", rsp_d1, 8'h11);
        applyStimulus();

        $display("[TB] A and B both valid continuously");
        setA(1, 0, 3'd3, 3'd7, 3'd0, 8'h00);
        setB(1, 0, 3'd7, 3'd3, 3'd0, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus();
        setA(0, 0, 0, 0, 0, 8'h00);
        setB(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();
        applyStimulus();

        $display("[TB] B raises valid during ISSUE then drops it");
        setA(1, 0, 3'd6, 3'd1, 3'd0, 8'h00);
        applyStimulus();
        setA(0, 0, 0, 0, 0, 8'h00);
        setB(1, 1, 3'd0, 3'd0, 3'd6, 8'h77);
        applyStimulus();
        setB(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();
        setA(1, 0, 3'd6, 3'd6, 3'd0, 8'h00);
        applyStimulus();
        setA(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();

        $display("[TB] reset asserted in the middle of ISSUE");
        setA(1, 1, 3'd5, 3'd5, 3'd5, 8'hFF);
        applyStimulus();
        setA(0, 0, 0, 0, 0, 8'h00);
        #1;
        checkOutput("mid_issue_w_en_before", rf_w_en, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("mid_issue_w_en_after", rf_w_en, 1'b0);
        checkOutput("mid_issue_r_en_after", rf_r_en, 1'b0);
        checkOutput("mid_issue_rsp_valid", rsp_valid, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus();
        setA(1, 0, 3'd5, 3'd3, 3'd0, 8'h00);
        applyStimulus();
        setA(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();
        checkOutput("r5_not_written", rsp_d1, 8'h00);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            setA($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            setB($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            applyStimulus();
        end
        setA(0, 0, 0, 0, 0, 8'h00);
        setB(0, 0, 0, 0, 0, 8'h00);
        applyStimulus();
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
